// File: rtl/uart_pkg.sv
// Shared UART scheduler types: FSM state encoding, default byte width, safe clog2.
// No logic; no latency or backpressure of its own.
// Imported by the TX scheduler and the round-robin picker.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } sched_state_t;

  // Never returns 0, so a 1-entry or 1-value range still gets a 1-bit signal.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr, wrapping modulo NUM_REQ.
// Latency: purely combinational, zero cycles.
// Backpressure: none; caller decides whether the winner is accepted.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IDX_W = clog2_safe(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  logic [IDX_W-1:0] idx;

  // Scan from the farthest offset down so the nearest valid requester wins.
  always_comb begin
    winner    = '0;
    idx       = '0;
    any_valid = |req_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
      if (req_valid[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin share of one UART TX engine among NUM_REQ requesters; UART_TX_BURST_EN adds req_last locking.
// Latency: byte accept to tx_start is 1 cycle; next accept earliest 3 + frame + GAP_CYCLES cycles later.
// Backpressure: req_ready only in IDLE, one requester at a time; engine busy holds the scheduler off.
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_W     = UART_DATA_W,
  parameter int GAP_CYCLES = 0,
  parameter int START_TMO  = 3,
  localparam int IDX_W = clog2_safe(NUM_REQ)
) (
  input  logic                      user_clock,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
`ifdef UART_TX_BURST_EN
  input  logic [NUM_REQ-1:0]        req_last,
`endif
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_start,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      active,
  output logic                      start_err
);

  localparam int TMO_W = clog2_safe(START_TMO + 1);
  localparam int GAP_W = clog2_safe(GAP_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(START_TMO - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam sched_state_t POST_FRAME = (GAP_CYCLES > 0) ? GAP : IDLE;

  sched_state_t     state, state_nxt;
  logic [IDX_W-1:0] ptr, winner_rr, pick, ptr_adv;
  logic             any_valid, pick_ok, xfer, tmo_hit, gap_done;
  logic [TMO_W-1:0] tmo_cnt;
  logic [GAP_W-1:0] gap_cnt;

  uart_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .winner    (winner_rr),
    .any_valid (any_valid)
  );

`ifdef UART_TX_BURST_EN
  logic locked;
  // While a burst is open only its owner may be served.
  assign pick    = locked ? grant_id : winner_rr;
  assign pick_ok = locked ? req_valid[grant_id] : any_valid;
`else
  assign pick    = winner_rr;
  assign pick_ok = any_valid;
`endif

  assign xfer     = (state == IDLE) && pick_ok && !rst;
  assign ptr_adv  = (pick == IDX_W'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
  assign tmo_hit  = (tmo_cnt == TMO_LAST);
  assign gap_done = (gap_cnt == GAP_LAST);

  always_ff @(posedge user_clock) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (xfer) state_nxt = ISSUE;
      ISSUE:     state_nxt = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)      state_nxt = WAIT_DONE;
        else if (tmo_hit) state_nxt = POST_FRAME;
      end
      WAIT_DONE: if (!tx_busy) state_nxt = POST_FRAME;
      GAP:       if (gap_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (xfer) req_ready[pick] = 1'b1;
    tx_start = (state == ISSUE);
    active   = (state != IDLE);
  end

  always_ff @(posedge user_clock) begin
    if (rst) begin
      tx_data   <= '0;
      grant_id  <= '0;
      ptr       <= '0;
      tmo_cnt   <= '0;
      gap_cnt   <= '0;
      start_err <= 1'b0;
`ifdef UART_TX_BURST_EN
      locked    <= 1'b0;
`endif
    end else begin
      if (xfer) begin
        tx_data  <= req_data[int'(pick)*DATA_W +: DATA_W];
        grant_id <= pick;
`ifdef UART_TX_BURST_EN
        if (req_last[pick]) begin
          ptr    <= ptr_adv;
          locked <= 1'b0;
        end else begin
          locked <= 1'b1;
        end
`else
        ptr      <= ptr_adv;
`endif
      end
      if (state == WAIT_BUSY) tmo_cnt <= tmo_cnt + 1'b1;
      else                    tmo_cnt <= '0;
      if ((state == WAIT_BUSY) && !tx_busy && tmo_hit) start_err <= 1'b1;
      // Gap counter holds at its terminal value rather than wrapping.
      if (state == GAP) gap_cnt <= gap_done ? gap_cnt : gap_cnt + 1'b1;
      else              gap_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: one no-gap instance, one GAP_CYCLES=5 instance.
// Table-driven single-request vectors plus hand sequences for rotation, gap, timeout, reset and bursts.
`timescale 1ns/1ps
module tb_uart_tx_sched;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [3:0]  valid0, ready0, valid1, ready1;
  logic [31:0] data0, data1;
  logic        busy0, start0, active0, err0;
  logic        busy1, start1, active1, err1;
  logic [7:0]  txd0, txd1;
  logic [1:0]  grant0, grant1;
`ifdef UART_TX_BURST_EN
  logic [3:0]  last0, last1;
`endif

  int checks = 0;
  int failures = 0;

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(0), .START_TMO(3)) u_dut (
    .user_clock (clk),
    .rst        (rst),
    .req_valid  (valid0),
    .req_data   (data0),
`ifdef UART_TX_BURST_EN
    .req_last   (last0),
`endif
    .req_ready  (ready0),
    .tx_start   (start0),
    .tx_data    (txd0),
    .tx_busy    (busy0),
    .grant_id   (grant0),
    .active     (active0),
    .start_err  (err0)
  );

  uart_tx_sched #(.NUM_REQ(4), .DATA_W(8), .GAP_CYCLES(5), .START_TMO(3)) u_gap (
    .user_clock (clk),
    .rst        (rst),
    .req_valid  (valid1),
    .req_data   (data1),
`ifdef UART_TX_BURST_EN
    .req_last   (last1),
`endif
    .req_ready  (ready1),
    .tx_start   (start1),
    .tx_data    (txd1),
    .tx_busy    (busy1),
    .grant_id   (grant1),
    .active     (active1),
    .start_err  (err1)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        busy;
    logic [3:0]  e_ready;
    logic        e_start;
    logic [7:0]  e_txd;
    logic [1:0]  e_grant;
    logic        e_active;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_start(input int which, input string name);
    int n;
    logic s;
    n = 0;
    s = 1'b0;
    do begin
      @(negedge clk);
      #1;
      n++;
      s = (which == 0) ? start0 : start1;
    end while (!s && n < 20);
    chk(name, 32'(s), 32'd1);
  endtask

  task automatic frame0();
    busy0 = 1'b1;
    repeat (3) @(negedge clk);
    busy0 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n;
    // inputs, then expected ready/start/tx_data/grant/active
    vecs[0]  = '{4'b0010, 32'h0000_4700, 1'b0, 4'b0010, 1'b0, 8'h00, 2'd0, 1'b0};
    vecs[1]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'h47, 2'd1, 1'b1};
    vecs[2]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'h47, 2'd1, 1'b1};
    vecs[3]  = '{4'b0001, 32'h0000_00FF, 1'b1, 4'b0000, 1'b0, 8'h47, 2'd1, 1'b1};
    vecs[4]  = '{4'b0000, 32'h0000_00EE, 1'b1, 4'b0000, 1'b0, 8'h47, 2'd1, 1'b1};
    vecs[5]  = '{4'b0001, 32'h0000_00FF, 1'b0, 4'b0000, 1'b0, 8'h47, 2'd1, 1'b1};
    vecs[6]  = '{4'b0001, 32'h0000_00FF, 1'b0, 4'b0001, 1'b0, 8'h47, 2'd1, 1'b0};
    vecs[7]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b1, 8'hFF, 2'd0, 1'b1};
    vecs[8]  = '{4'b0000, 32'h0000_0000, 1'b1, 4'b0000, 1'b0, 8'hFF, 2'd0, 1'b1};
    vecs[9]  = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'hFF, 2'd0, 1'b1};
    vecs[10] = '{4'b0000, 32'h0000_0000, 1'b0, 4'b0000, 1'b0, 8'hFF, 2'd0, 1'b0};

    rst = 1'b1;
    valid0 = '0; data0 = '0; busy0 = 1'b0;
    valid1 = '0; data1 = '0; busy1 = 1'b0;
`ifdef UART_TX_BURST_EN
    last0 = '1; last1 = '1;
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_ready",  32'(ready0),  32'd0);
    chk("rst_start",  32'(start0),  32'd0);
    chk("rst_txd",    32'(txd0),    32'd0);
    chk("rst_grant",  32'(grant0),  32'd0);
    chk("rst_active", 32'(active0), 32'd0);
    chk("rst_err",    32'(err0),    32'd0);
    chk("rst_g_active", 32'(active1), 32'd0);
    chk("rst_g_txd",  32'(txd1),    32'd0);

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      valid0 = vecs[i].valid;
      data0  = vecs[i].data;
      busy0  = vecs[i].busy;
      #1;
      chk($sformatf("vec%0d_ready", i),  32'(ready0),  32'(vecs[i].e_ready));
      chk($sformatf("vec%0d_start", i),  32'(start0),  32'(vecs[i].e_start));
      chk($sformatf("vec%0d_txd", i),    32'(txd0),    32'(vecs[i].e_txd));
      chk($sformatf("vec%0d_grant", i),  32'(grant0),  32'(vecs[i].e_grant));
      chk($sformatf("vec%0d_active", i), 32'(active0), 32'(vecs[i].e_active));
    end

    // Rotation: all four requesters valid from ptr=0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    valid0 = 4'hF;
    data0  = 32'hA3A2_A1A0;
    for (int k = 0; k < 5; k++) begin
      wait_start(0, "rot_start");
      chk("rot_data",  32'(txd0),   32'(8'hA0 + 8'(k % 4)));
      chk("rot_grant", 32'(grant0), 32'(k % 4));
      if (k == 4) valid0 = '0;
      frame0();
    end

    // Inter-frame gap on the GAP_CYCLES=5 instance.
    valid1 = 4'b0011;
    data1  = 32'h0000_2211;
    wait_start(1, "gap_start1");
    chk("gap_txd1", 32'(txd1), 32'h11);
    busy1 = 1'b1;
    repeat (3) @(negedge clk);
    busy1 = 1'b0;
    #1;
    chk("gap_ready_at_fall", 32'(ready1), 32'd0);
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (ready1 == 4'd0 && n < 20);
    chk("gap_cycles_between", 32'(n - 1), 32'd5);
    chk("gap_ready2", 32'(ready1), 32'b0010);
    valid1 = 4'b0010;
    wait_start(1, "gap_start2");
    chk("gap_txd2", 32'(txd1), 32'h22);
    valid1 = '0;
    busy1 = 1'b1;
    repeat (3) @(negedge clk);
    busy1 = 1'b0;

    // Start timeout: engine never raises busy.
    valid0 = 4'b0100;
    data0  = 32'h005A_0000;
    wait_start(0, "tmo_start");
    chk("tmo_txd", 32'(txd0), 32'h5A);
    valid0 = '0;
    chk("tmo_err_issue", 32'(err0), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      #1;
      chk($sformatf("tmo_err_c%0d", i), 32'(err0), (i == 4) ? 32'd1 : 32'd0);
    end
    chk("tmo_idle", 32'(active0), 32'd0);
    valid0 = 4'b1000;
    data0  = 32'h3C00_0000;
    wait_start(0, "tmo_next_start");
    chk("tmo_next_txd",   32'(txd0),   32'h3C);
    chk("tmo_next_grant", 32'(grant0), 32'd3);
    valid0 = '0;
    frame0();
    chk("tmo_sticky", 32'(err0), 32'd1);

    // Reset in WAIT_DONE, with ptr left at 3 beforehand.
    valid0 = 4'b0100;
    data0  = 32'h0077_0000;
    wait_start(0, "rst_mid_start");
    chk("rst_mid_grant", 32'(grant0), 32'd2);
    valid0 = '0;
    busy0 = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_mid_active", 32'(active0), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_ready",  32'(ready0),  32'd0);
    chk("rst_mid_start",  32'(start0),  32'd0);
    chk("rst_mid_txd",    32'(txd0),    32'd0);
    chk("rst_mid_grant0", 32'(grant0),  32'd0);
    chk("rst_mid_idle",   32'(active0), 32'd0);
    chk("rst_mid_err",    32'(err0),    32'd0);
    busy0  = 1'b0;
    valid0 = 4'b1100;
    data0  = 32'h3322_0000;
    #1;
    chk("rst_ptr_ready", 32'(ready0), 32'b0100);
    wait_start(0, "rst_ptr_start");
    chk("rst_ptr_txd",   32'(txd0),   32'h22);
    chk("rst_ptr_grant", 32'(grant0), 32'd2);
    valid0 = '0;
    frame0();

`ifdef UART_TX_BURST_EN
    // Burst: requester 0 holds the engine for three bytes while requester 1 waits.
    valid0 = 4'b0011;
    data0  = 32'h0000_C1B0;
    last0  = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      wait_start(0, "burst_start");
      chk($sformatf("burst%0d_grant", k), 32'(grant0), (k < 3) ? 32'd0 : 32'd1);
      chk($sformatf("burst%0d_txd", k), 32'(txd0), (k < 3) ? 32'(8'hB0 + 8'(k)) : 32'hC1);
      if (k < 2) data0[7:0] = 8'hB0 + 8'(k + 1);
      if (k == 1) last0[0] = 1'b1;
      if (k == 2) valid0[0] = 1'b0;
      if (k == 3) valid0 = '0;
      frame0();
      if (k < 3) chk($sformatf("burst%0d_grant_held", k), 32'(grant0), 32'd0);
    end
`endif

    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
